// File: rtl/gcl_scheduler.sv
// Gate-control-list scheduler: walks a 32-entry GCL RAM, presenting one 8-bit
// gate vector per time slot and prefetching the next entry inside each slot.
module gcl_scheduler #(
  parameter PLATFORM = "xilinx"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_update_finish,
  input  logic         in_test_stop,
  input  logic [19:0]  in_time_slot_cycle,
  output logic         out_gcl_rd,
  output logic [4:0]   out_gcl_addr,
  input  logic [127:0] in_gcl_rdata,
  output logic [7:0]   out_gate_ctrl,
  output logic [4:0]   out_slot_idx,
  output logic         out_slot_start
);

  typedef enum logic [1:0] {IDLE, FETCH0, FILL0, RUN} state_t;

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] eff_q, eff_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  gate_q, gate_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        ss_q, ss_d;
  logic [19:0] eff_in;

  // Only the low byte of a GCL word carries gate bits; the vendor tag is informational.
  logic unused_ok;
  assign unused_ok = ^{in_gcl_rdata[127:8], (PLATFORM == "xilinx")};

  // Slots shorter than 4 cycles cannot fit the read/capture/load sequence.
  assign eff_in = (in_time_slot_cycle < 20'd4) ? 20'd4 : in_time_slot_cycle;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    eff_d    = eff_q;
    shadow_d = shadow_q;
    gate_d   = gate_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    rd_d     = 1'b0;
    ss_d     = 1'b0;
    if (in_test_stop) begin
      state_d = IDLE;
      gate_d  = 8'h00;
      cnt_d   = 20'd0;
    end else if (in_update_finish) begin
      // Restart from entry 0 from any state; gates hold until entry 0 lands.
      state_d = FETCH0;
      rd_d    = 1'b1;
      addr_d  = 5'd0;
      cnt_d   = 20'd0;
    end else begin
      case (state_q)
        IDLE: cnt_d = 20'd0;
        FETCH0: state_d = FILL0;
        FILL0: begin
          shadow_d = in_gcl_rdata[7:0];
          gate_d   = shadow_d;
          idx_d    = 5'd0;
          ss_d     = 1'b1;
          cnt_d    = 20'd0;
          eff_d    = eff_in;
          state_d  = RUN;
        end
        RUN: begin
          cnt_d = cnt_q + 20'd1;
          if (cnt_q == eff_q - 20'd3) begin
            rd_d   = 1'b1;
            addr_d = idx_q + 5'd1;
          end
          // Prefetched word is on the bus in the last cycle of the slot.
          if (cnt_q == eff_q - 20'd1) begin
            shadow_d = in_gcl_rdata[7:0];
            gate_d   = shadow_d;
            idx_d    = idx_q + 5'd1;
            ss_d     = 1'b1;
            cnt_d    = 20'd0;
            eff_d    = eff_in;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 20'd0;
      eff_q    <= 20'd4;
      shadow_q <= 8'h00;
      gate_q   <= 8'h00;
      idx_q    <= 5'd0;
      addr_q   <= 5'd0;
      rd_q     <= 1'b0;
      ss_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eff_q    <= eff_d;
      shadow_q <= shadow_d;
      gate_q   <= gate_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      ss_q     <= ss_d;
    end
  end

  assign out_gcl_rd     = rd_q;
  assign out_gcl_addr   = addr_q;
  assign out_gate_ctrl  = gate_q;
  assign out_slot_idx   = idx_q;
  assign out_slot_start = ss_q;

endmodule

// File: tb/tb_gcl_scheduler.sv
// Random + directed bench for gcl_scheduler against a slot-timeline model:
// each slot is a start cycle plus a length, with the prefetch two cycles before its end.
module tb_gcl_scheduler;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_update_finish = 1'b0;
  logic         in_test_stop = 1'b0;
  logic [19:0]  in_time_slot_cycle = 20'd10;
  logic         out_gcl_rd;
  logic [4:0]   out_gcl_addr;
  logic [127:0] in_gcl_rdata = '0;
  logic [7:0]   out_gate_ctrl;
  logic [4:0]   out_slot_idx;
  logic         out_slot_start;

  gcl_scheduler #(.PLATFORM("xilinx")) dut (
    .clk(clk), .rst_n(rst_n),
    .in_update_finish(in_update_finish), .in_test_stop(in_test_stop),
    .in_time_slot_cycle(in_time_slot_cycle),
    .out_gcl_rd(out_gcl_rd), .out_gcl_addr(out_gcl_addr), .in_gcl_rdata(in_gcl_rdata),
    .out_gate_ctrl(out_gate_ctrl), .out_slot_idx(out_slot_idx), .out_slot_start(out_slot_start)
  );

  always #5 clk = ~clk;

  // GCL RAM: word valid one cycle after the strobe, noise otherwise and in the upper bits.
  logic [7:0]   ram [32];
  logic [127:0] noise;
  always @(posedge clk) begin
    noise = {$urandom, $urandom, $urandom, $urandom};
    if (out_gcl_rd) noise[7:0] = ram[out_gcl_addr];
    in_gcl_rdata <= noise;
  end

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, t);
    end
  endtask

  // Timeline model state
  bit         m_act, m_first, e_rd, e_ss;
  int         m_next, m_rd_at, eff;
  logic [4:0] m_idx, m_rd_addr, e_addr;
  logic [7:0] m_gate;

  task automatic model_reset();
    m_act = 0; m_first = 0; e_rd = 0; e_ss = 0;
    m_idx = 5'd0; m_gate = 8'h00; m_next = -1; m_rd_at = -1;
  endtask

  // Check current cycle, drive inputs for it, predict the next cycle.
  task automatic step(input bit s, input bit u, input logic [19:0] c);
    @(negedge clk);
    chk("slot_start", 32'(out_slot_start), 32'(e_ss));
    chk("gcl_rd", 32'(out_gcl_rd), 32'(e_rd));
    if (e_rd) chk("gcl_addr", 32'(out_gcl_addr), 32'(e_addr));
    chk("gate_ctrl", 32'(out_gate_ctrl), 32'(m_gate));
    chk("slot_idx", 32'(out_slot_idx), 32'(m_idx));
    in_test_stop = s; in_update_finish = u; in_time_slot_cycle = c;
    e_rd = 0; e_ss = 0;
    if (s) begin
      m_act = 0; m_gate = 8'h00;
    end else if (u) begin
      m_act = 1; m_first = 1; m_next = t + 3; m_rd_at = t + 1; m_rd_addr = 5'd0;
    end
    if (m_act && t + 1 == m_rd_at) begin
      e_rd = 1; e_addr = m_rd_addr;
    end
    if (m_act && t + 1 == m_next) begin
      e_ss = 1;
      m_idx = m_first ? 5'd0 : 5'((m_idx + 1) % 32);
      m_first = 0;
      m_gate = ram[m_idx];
      eff = (c < 4) ? 4 : int'(c);
      m_next = t + 1 + eff;
      m_rd_at = m_next - 2;
      m_rd_addr = 5'((m_idx + 1) % 32);
    end
    t++;
  endtask

  bit          stop_lvl;
  logic [19:0] cyc;

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 8'(i + 1);
    model_reset();
    #2;
    chk("rst_gate", 32'(out_gate_ctrl), 32'h0);
    chk("rst_idx", 32'(out_slot_idx), 32'h0);
    chk("rst_addr", 32'(out_gcl_addr), 32'h0);
    chk("rst_rd", 32'(out_gcl_rd), 32'h0);
    chk("rst_ss", 32'(out_slot_start), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Entry i = i+1, 10-cycle slots, 33+ slots to see the 31 -> 0 wrap
    step(0, 1, 20'd10);
    for (int i = 0; i < 345; i++) step(0, 0, 20'd10);
    // Short cycle clamps to 4; mid-slot change only affects later slots
    for (int i = 0; i < 24; i++) step(0, 0, 20'd1);
    for (int i = 0; i < 15; i++) step(0, 0, 20'd10);
    for (int i = 0; i < 5; i++)  step(0, 0, 20'd6);
    for (int i = 0; i < 30; i++) step(0, 0, 20'd6);
    // Stop, then update while stopped is ignored
    step(1, 0, 20'd10);
    for (int i = 0; i < 4; i++) step(1, 1, 20'd10);
    for (int i = 0; i < 8; i++) step(0, 0, 20'd10);
    // Restart exactly on a prefetch-decision cycle after 7 slots
    step(0, 1, 20'd10);
    for (int i = 0; i < 72; i++) step(0, 0, 20'd10);
    for (int i = 0; i < 40 && t != m_rd_at - 1; i++) step(0, 0, 20'd10);
    chk("prefetch_align", t, m_rd_at - 1);
    step(0, 1, 20'd10);
    for (int i = 0; i < 30; i++) step(0, 0, 20'd10);

    // Random phase with fresh RAM contents
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom);
    stop_lvl = 0; cyc = 20'd7;
    for (int i = 0; i < 4000; i++) begin
      if (!stop_lvl && $urandom_range(149) == 0) stop_lvl = 1;
      else if (stop_lvl && $urandom_range(9) == 0) stop_lvl = 0;
      if ($urandom_range(24) == 0) cyc = 20'($urandom_range(12));
      step(stop_lvl, $urandom_range(59) == 0, cyc);
    end

    // Async reset in the middle of a running slot
    step(0, 1, 20'd9);
    for (int i = 0; i < 25; i++) step(0, 0, 20'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gate", 32'(out_gate_ctrl), 32'h0);
    chk("arst_idx", 32'(out_slot_idx), 32'h0);
    chk("arst_addr", 32'(out_gcl_addr), 32'h0);
    chk("arst_rd", 32'(out_gcl_rd), 32'h0);
    chk("arst_ss", 32'(out_slot_start), 32'h0);
    model_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 20'd9);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(0, 0, 20'd9);
    step(0, 1, 20'd5);
    for (int i = 0; i < 30; i++) step(0, 0, 20'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
